// File: rtl/sdspi_pkg.sv
// Shared SD data-path definitions: transfer FSM encoding, block size and data
// tokens used by the block sequencer, llsddata and the bus controller.
package sdspi_pkg;

  localparam int         SD_LGBLK       = 9;
  localparam logic [7:0] SD_TOKEN_START = 8'hFE;
  localparam logic [7:0] SD_TOKEN_WRACK = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LOAD,
    ST_WR_SEND,
    ST_WR_DRAIN,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_DONE
  } xfer_state_t;

  function automatic logic is_rd_state(input xfer_state_t s);
    return (s == ST_RD_WAIT) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/sdxfer_timeout.sv
// Read start-token watchdog: counts enabled SD clock edges and pulses expire on
// the edge that brings the count to its all-ones value.
module sdxfer_timeout #(
  parameter int LGTIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [LGTIMEOUT-1:0] PRE_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  logic [LGTIMEOUT-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  cnt_q <= '0;
    else if (i_clr)  cnt_q <= '0;
    else if (i_en)   cnt_q <= cnt_q + 1'b1;
  end

  assign o_expire = i_en & ~i_clr & (cnt_q == PRE_LAST);

endmodule

// File: rtl/sdblock_xfer.sv
// Moves one sector between the local buffer RAM and llsddata. Buffer read data
// for o_buf_addr must be valid by the clock edge that ends the cycle it is presented.
module sdblock_xfer
  import sdspi_pkg::*;
#(
  parameter int LGBLK     = SD_LGBLK,
  parameter int LGTIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_abort,
  input  logic             i_pedge,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_timeout,
  output logic [LGBLK-1:0] o_buf_addr,
  output logic             o_buf_we,
  output logic [7:0]       o_buf_wdata,
  input  logic [7:0]       i_buf_data,
  output logic             o_ll_stb,
  output logic [7:0]       o_ll_byte,
  input  logic             i_ll_busy,
  output logic             o_ll_expect,
  input  logic             i_ll_stb,
  input  logic [7:0]       i_ll_byte,
  input  logic             i_ll_err
);

  localparam logic [LGBLK-1:0] LAST_ADDR = '1;

  xfer_state_t      state_q, state_d;
  logic [LGBLK-1:0] addr_q, addr_d;
  logic [7:0]       llbyte_q, llbyte_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic             tmr_clr, tmr_en, tmr_expire;
  logic             rd;

  sdxfer_timeout #(.LGTIMEOUT(LGTIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (tmr_clr),
    .i_en      (tmr_en),
    .o_expire  (tmr_expire)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      llbyte_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      llbyte_q <= llbyte_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    llbyte_d = llbyte_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    tmr_clr  = 1'b0;
    rd       = is_rd_state(state_q);
    tmr_en   = (state_q == ST_RD_WAIT) & i_pedge;

    // Read side: address advances once the write of the current byte has gone out.
    if (rd && i_ll_err) err_d = 1'b1;
    if (rd && we_q)     addr_d = addr_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d  = 1'b0;
          tmo_d  = 1'b0;
          addr_d = '0;
          if (i_dir) begin
            state_d = ST_RD_WAIT;
            tmr_clr = 1'b1;
          end else begin
            state_d = ST_WR_LOAD;
          end
        end
      end
      ST_WR_LOAD: begin
        llbyte_d = i_buf_data;
        state_d  = ST_WR_SEND;
      end
      ST_WR_SEND: begin
        if (!i_ll_busy) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_WR_DRAIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_WR_LOAD;
          end
        end
      end
      ST_WR_DRAIN: begin
        if (!i_ll_busy) state_d = ST_DONE;
      end
      ST_RD_WAIT: begin
        // A byte arriving on the expiry edge means the token made it in time.
        if (i_ll_stb) begin
          we_d    = 1'b1;
          wdata_d = i_ll_byte;
          state_d = ST_RD_DATA;
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD_DATA: begin
        if (we_q && addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else if (i_ll_stb) begin
          we_d    = 1'b1;
          wdata_d = i_ll_byte;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (i_abort && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_DONE;
      err_d   = 1'b1;
      we_d    = 1'b0;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_timeout   = tmo_q;
  assign o_buf_addr  = addr_q;
  assign o_buf_we    = we_q;
  assign o_buf_wdata = wdata_q;
  assign o_ll_stb    = (state_q == ST_WR_SEND);
  assign o_ll_byte   = llbyte_q;
  assign o_ll_expect = is_rd_state(state_q);

endmodule

// File: tb/tb_sdblock_xfer.sv
// Scoreboard bench for sdblock_xfer: buffer RAM and llsddata are modelled here,
// expected bytes are queued at stimulus time and popped as the DUT emits them.
module tb_sdblock_xfer;

  localparam int NBYTES = 512;
  localparam int LGTO   = 4;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, dir = 1'b0, abort = 1'b0, pedge = 1'b0;
  logic       ll_busy = 1'b0, ll_stb_in = 1'b0, ll_err = 1'b0;
  logic [7:0] ll_byte_in = 8'h00;
  logic [7:0] buf_rdata;
  logic       o_busy, o_done, o_err, o_timeout, o_buf_we, o_ll_stb, o_ll_expect;
  logic [8:0] o_buf_addr;
  logic [7:0] o_buf_wdata, o_ll_byte;

  typedef struct packed { logic [8:0] a; logic [7:0] d; } wr_t;

  logic [7:0] mem [NBYTES];
  logic [7:0] exp_bq[$];
  wr_t        exp_wq[$];
  int         fill_kind = 0;
  int         n_chk = 0, n_fail = 0;

  sdblock_xfer #(.LGBLK(9), .LGTIMEOUT(LGTO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_dir(dir), .i_abort(abort),
    .i_pedge(pedge), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_timeout(o_timeout), .o_buf_addr(o_buf_addr), .o_buf_we(o_buf_we),
    .o_buf_wdata(o_buf_wdata), .i_buf_data(buf_rdata), .o_ll_stb(o_ll_stb),
    .o_ll_byte(o_ll_byte), .i_ll_busy(ll_busy), .o_ll_expect(o_ll_expect),
    .i_ll_stb(ll_stb_in), .i_ll_byte(ll_byte_in), .i_ll_err(ll_err)
  );

  always #5 clk = ~clk;

  assign buf_rdata = mem[o_buf_addr];

  always @(posedge clk) begin
    if (fill_kind == 1)      for (int a = 0; a < NBYTES; a++) mem[a] <= 8'(a) ^ 8'h5A;
    else if (fill_kind == 2) for (int a = 0; a < NBYTES; a++) mem[a] <= 8'hEE;
    else if (o_buf_we)       mem[o_buf_addr] <= o_buf_wdata;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_fill(input int k);
    fill_kind = k; tick(); fill_kind = 0;
  endtask

  task automatic check_all_zero(input string nm);
    n_chk++;
    if ({o_busy, o_done, o_err, o_timeout, o_buf_we, o_ll_stb, o_ll_expect} !== 7'b0 ||
        o_buf_addr !== 9'd0 || o_buf_wdata !== 8'd0 || o_ll_byte !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: flags=%b addr=%0d wdata=%h llbyte=%h, required all 0", nm,
               {o_busy, o_done, o_err, o_timeout, o_buf_we, o_ll_stb, o_ll_expect},
               o_buf_addr, o_buf_wdata, o_ll_byte);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
  endtask

  // Full or partial write; stop_after>=0 returns just before that accept completes.
  task automatic run_write(input int stop_after, input logic err_noise, input string nm);
    int acc = 0, cyc = 0, busy_cnt = 0, ndone = 0;
    logic [8:0] done_addr = '0;
    logic       done_err = 1'b1;
    logic [7:0] e;
    exp_bq.delete();
    do_fill(1);
    for (int a = 0; a < NBYTES; a++) exp_bq.push_back(8'(a) ^ 8'h5A);
    ll_err = err_noise;
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    n_chk++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b err=%b, required busy=1 err=0", nm, o_busy, o_err);
    end
    while (cyc < BUDGET) begin
      if (o_done) begin
        ndone++; done_addr = o_buf_addr; done_err = o_err;
        break;
      end
      ll_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
      if (o_ll_stb && !ll_busy) begin
        if (acc == stop_after) begin
          ll_err = 1'b0;
          return;
        end
        e = (exp_bq.size() != 0) ? exp_bq.pop_front() : 8'hXX;
        n_chk++;
        if (o_ll_byte !== e) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %h, required %h", nm, acc, o_ll_byte, e);
        end
        acc++;
        busy_cnt = 8;
      end
      tick(); cyc++;
    end
    ll_busy = 1'b0; ll_err = 1'b0;
    n_chk++;
    if (cyc >= BUDGET || acc != NBYTES || exp_bq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count: accepted %0d left %0d cycles %0d, required %0d left 0",
               nm, acc, exp_bq.size(), cyc, NBYTES);
    end
    n_chk++;
    if (done_err !== 1'b0 || done_addr !== 9'd511) begin
      n_fail++;
      $display("FAIL %s_done: err=%b addr=%0d, required err=0 addr=511", nm, done_err, done_addr);
    end
    tick();
    n_chk++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: done=%b busy=%b, required 0 0", nm, o_done, o_busy);
    end
  endtask

  task automatic run_read(input int err_at, input string nm);
    int sent = 0, gap = 0, n_we = 0, cyc = 0, last_we = -10, done_cyc = -1, bad = 0;
    logic done_err = 1'b0, done_tmo = 1'b1, done_exp = 1'b1;
    wr_t w;
    exp_wq.delete();
    do_fill(2);
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < BUDGET) begin
      if (o_buf_we) begin
        n_we++; last_we = cyc;
        w = (exp_wq.size() != 0) ? exp_wq.pop_front() : 'x;
        n_chk++;
        if (o_buf_addr !== w.a || o_buf_wdata !== w.d) begin
          n_fail++;
          $display("FAIL %s_we%0d: addr=%0d data=%h, required addr=%0d data=%h",
                   nm, n_we, o_buf_addr, o_buf_wdata, w.a, w.d);
        end
      end
      if (o_done) begin
        done_cyc = cyc; done_err = o_err; done_tmo = o_timeout; done_exp = o_ll_expect;
        break;
      end
      ll_stb_in = 1'b0; ll_err = 1'b0;
      if (sent < NBYTES) begin
        if (gap == 0) begin
          ll_stb_in  = 1'b1;
          ll_byte_in = 8'(sent);
          ll_err     = (sent == err_at);
          exp_wq.push_back(wr_t'{a: 9'(sent), d: 8'(sent)});
          sent++;
          gap = $urandom_range(0, 3);
        end else gap--;
      end
      tick(); cyc++;
    end
    ll_stb_in = 1'b0; ll_err = 1'b0;
    n_chk++;
    if (n_we != NBYTES || exp_wq.size() != 0 || done_cyc != last_we + 1) begin
      n_fail++;
      $display("FAIL %s_count: writes %0d left %0d done@%0d lastwe@%0d, required %0d 0 lastwe+1",
               nm, n_we, exp_wq.size(), done_cyc, last_we, NBYTES);
    end
    n_chk++;
    if (done_err !== (err_at >= 0) || done_tmo !== 1'b0 || done_exp !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: err=%b tmo=%b expect=%b, required err=%b tmo=0 expect=0",
               nm, done_err, done_tmo, done_exp, (err_at >= 0));
    end
    tick();
    for (int a = 0; a < NBYTES; a++) if (mem[a] !== 8'(a)) bad++;
    n_chk++;
    if (bad != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_mem: %0d bad locations busy=%b, required 0 busy=0", nm, bad, o_busy);
    end
  endtask

  task automatic test_write();      run_write(-1, 1'b0, "write");      endtask
  task automatic test_read();       run_read(-1, "read");              endtask
  task automatic test_read_err();   run_read(100, "read_err");         endtask
  task automatic test_write_noise(); run_write(-1, 1'b1, "write_noise"); endtask

  task automatic test_timeout();
    int cyc = 0, n_we = 0;
    do_fill(2);
    start = 1'b1; dir = 1'b1; pedge = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 100 && !o_done) begin
      if (o_buf_we) n_we++;
      tick(); cyc++;
    end
    n_chk++;
    if (!o_done || cyc < 14 || cyc > 18 || o_err !== 1'b1 || o_timeout !== 1'b1 || n_we != 0) begin
      n_fail++;
      $display("FAIL timeout: done=%b cycles=%0d err=%b tmo=%b we=%0d, required 1 14..18 1 1 0",
               o_done, cyc, o_err, o_timeout, n_we);
    end
    pedge = 1'b0;
    tick();
    n_chk++;
    if (o_err !== 1'b1 || o_timeout !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hold: err=%b tmo=%b busy=%b, required 1 1 0", o_err, o_timeout, o_busy);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ll_stb_in = 1'b1; ll_byte_in = 8'(i);
      tick();
    end
    ll_stb_in = 1'b0;
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    n_chk++;
    if (o_ll_expect !== 1'b1 || o_ll_stb !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: expect=%b stb=%b busy=%b done=%b, required 1 0 1 0",
               o_ll_expect, o_ll_stb, o_busy, o_done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_chk++;
    if (o_done !== 1'b1 || o_err !== 1'b1 || o_ll_expect !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: done=%b err=%b expect=%b tmo=%b, required 1 1 0 0",
               o_done, o_err, o_ll_expect, o_timeout);
    end
    tick();
    n_chk++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_reset_mid();
    run_write(37, 1'b0, "pre_reset");
    n_chk++;
    if (o_busy !== 1'b1 || o_buf_addr !== 9'd37) begin
      n_fail++;
      $display("FAIL pre_reset_pos: busy=%b addr=%0d, required 1 37", o_busy, o_buf_addr);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    ll_busy = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    run_write(-1, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_err();
    test_write_noise();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
